mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Responder to the Controller's Start/HiLoWr outputs: performs mult/multu/div/divu with
//  fixed multi-cycle latency and holds the architectural HI/LO registers. Sits in the
//  execute stage beside the ALU. The pipeline stalls on Busy. mfhi/mflo read HI/LO directly.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu (>=1)
//  DIV_CYCLES   10  cycles Busy stays high for div/divu (>=1)
// PORTS
//  clk      in   1   system clock, rising edge
//  reset    in   1   synchronous, active-high
//  Start    in   1   launch operation selected by MDOp (from Controller)
//  MDOp     in   2   00 mult, 01 multu, 10 div, 11 divu
//  A        in   32  rs operand; also write data for mthi/mtlo
//  B        in   32  rt operand
//  HiLoWr   in   2   01 write HI<=A, 10 write LO<=A, 00/11 no write
//  Busy     out  1   operation in flight
//  HI       out  32  HI register (registered)
//  LO       out  32  LO register (registered)
// BEHAVIOUR
//  - Reset: HI=0, LO=0, Busy=0, counter=0, pending result cleared. Any operation in flight is abandoned.
//  - Accept: at edge E0 with Start=1 and Busy=0, compute the 64-bit result, latch it into a pending
//    register, and load counter=MULT_CYCLES or DIV_CYCLES. Busy=(counter!=0), registered.
//  - Each edge with counter!=0 decrements the counter. At the edge where counter==1, HI/LO<=pending.
//    New HI/LO are visible the cycle after Busy falls. Total: Busy high N cycles after E0.
//  - mult:  {HI,LO} = $signed(A)*$signed(B) (64-bit); multu: unsigned product.
//  - div:   LO=signed quotient truncated toward zero; HI=remainder with the sign of A.
//  - divu:  unsigned quotient/remainder.
//  - Divide by zero (B==0): the operation runs its full DIV_CYCLES. HI/LO are left unchanged at completion.
//  - div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//  - Start while Busy=1: ignored (no relaunch, no operand capture). The Controller must stall.
//  - HiLoWr while Busy=1: ignored.
//  - HiLoWr and Start in the same idle cycle: the HiLoWr write happens at E0. The result later overwrites both HI and LO.
//  - Busy does not combinationally include Start. The stall logic ORs Start externally.
// CONFIGURATION
//  MDU_CANCEL_EN defined: adds input port `Cancel` (1 bit, placed after HiLoWr).
//    Cancel=1 clears the counter and pending result at that edge; HI/LO are not updated and Busy=0 next cycle.
//    Cancel has priority over Start and HiLoWr in the same cycle. It is used for exception flush.
//  MDU_CANCEL_EN undefined: no Cancel port. An operation, once accepted, always completes.
// STRUCTURE
//  - Shared header (with the instruction decode macros): MDOp encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
//    and HiLoWr encodings HL_NONE/HL_HI/HL_LO.
//  - Sub-module mdu_latency_counter: load value, decrement, done pulse on the 1->0 step, busy flag.
//  - Arithmetic and HI/LO registers stay in mult_div_unit.
// TESTING
//  1 mult A=0xFFFFFFFF B=2 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE
//  2 multu A=0xFFFFFFFF B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles
//  3 div A=-7 B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3, HI=1
//  4 HI=0x11,LO=0x22 then divu B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged
//  5 during mult: Start(divu) and HiLoWr=01 A=0x55 -> both ignored; mult result lands on schedule
//  6 reset at cycle 3 of div -> next cycle Busy=0, HI=LO=0; MDU_CANCEL_EN: Cancel at cycle 2 -> HI/LO kept

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit and the decode logic.
// MDOp selects the operation; HiLoWr selects a direct HI/LO write.
package mult_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] HL_NONE = 2'b00;
    localparam logic [1:0] HL_HI   = 2'b01;
    localparam logic [1:0] HL_LO   = 2'b10;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mult_div_unit_latency_counter.sv
// Latency counter for the multiply/divide unit.
// Ports: clk, reset (sync, active-high), clear (abandon), load, load_val,
//        busy (count != 0), done (last busy cycle: count == 1).
module mdu_latency_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load && count == '0) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);
    // Asserted during the cycle whose closing edge takes count 1 -> 0.
    assign done = (count == W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Fixed-latency mult/multu/div/divu unit holding the HI/LO registers.
// Ports: clk, reset, Start, MDOp, A, B, HiLoWr, [Cancel], Busy, HI, LO.
// Optional feature: define MDU_CANCEL_EN to add the Cancel (flush) input.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  HiLoWr,
`ifdef MDU_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    logic cancel;
`ifdef MDU_CANCEL_EN
    assign cancel = Cancel;
`else
    assign cancel = 1'b0;
`endif

    logic          accept;
    logic          done;
    logic [CW-1:0] load_val;

    assign accept   = Start && !Busy;
    assign load_val = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    mdu_latency_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cancel),
        .load     (accept),
        .load_val (load_val),
        .busy     (Busy),
        .done     (done)
    );

    // Products
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Division on magnitudes, then sign fix-up. This keeps the
    // 0x80000000 / -1 case well defined: the quotient wraps to 0x80000000.
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sgn   = (MDOp == MD_DIV);
    assign a_neg = sgn && A[31];
    assign b_neg = sgn && B[31];
    assign a_mag = a_neg ? (~A + 32'd1) : A;
    assign b_mag = b_neg ? (~B + 32'd1) : B;
    assign uq    = (b_mag == '0) ? '0 : a_mag / b_mag;
    assign ur    = (b_mag == '0) ? '0 : a_mag % b_mag;
    assign quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign rem   = a_neg ? (~ur + 32'd1) : ur;

    logic [63:0] result;
    logic        result_wr;

    always_comb begin
        result    = '0;
        result_wr = 1'b1;
        case (MDOp)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            default: begin
                result    = {rem, quo};
                result_wr = (B != '0);
            end
        endcase
    end

    logic [63:0] pend;
    logic        pend_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
        end else if (cancel) begin
            pend    <= '0;
            pend_wr <= 1'b0;
        end else if (!Busy) begin
            if (HiLoWr == HL_HI) HI <= A;
            if (HiLoWr == HL_LO) LO <= A;
            if (Start) begin
                pend    <= result;
                pend_wr <= result_wr;
            end
        end else if (done && pend_wr) begin
            {HI, LO} <= pend;
        end
    end

endmodule
